// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master for the interval timer: programs the period, runs it in continuous
// mode, acknowledges each timeout and fans each tick out to N_CH countdown channels.
module timer_tick_scheduler #(
    parameter int N_CH       = 4,
    parameter int TICK_W     = 16,
    parameter int MIN_PERIOD = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              cfg_period,
    input  logic                     cfg_start,
    input  logic                     cfg_stop,
    output logic                     running,
    output logic [31:0]              tick_count,
    output logic [2:0]               tmr_address,
    output logic                     tmr_chipselect,
    output logic                     tmr_write_n,
    output logic [15:0]              tmr_writedata,
    input  logic                     tmr_irq,
    input  logic [N_CH-1:0]          ch_load,
    input  logic [N_CH*TICK_W-1:0]   ch_ticks,
    input  logic [N_CH-1:0]          ch_cancel,
    output logic [N_CH-1:0]          ch_busy,
    output logic [N_CH-1:0]          ch_expire
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_PL   = 3'd1,
        S_WR_PH   = 3'd2,
        S_WR_CTL  = 3'd3,
        S_RUN     = 3'd4,
        S_CLR_STS = 3'd5,
        S_TICK    = 3'd6,
        S_WR_STOP = 3'd7
    } state_t;

    state_t                        state_q, state_d;
    logic [31:0]                   period_q, period_d;
    logic                          stop_pend_q, stop_pend_d;
    logic                          running_q, running_d;
    logic [31:0]                   tick_count_q, tick_count_d;
    logic [2:0]                    addr_q, addr_d;
    logic                          cs_q, cs_d;
    logic                          wr_n_q, wr_n_d;
    logic [15:0]                   wdata_q, wdata_d;
    logic [N_CH-1:0][TICK_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]               busy_q, busy_d;
    logic [N_CH-1:0]               expire_q, expire_d;

    // Sequencer next-state, latched period, pending stop and tick counter.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        stop_pend_d  = stop_pend_q;
        tick_count_d = tick_count_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    period_d = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;
                    state_d  = S_WR_PL;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_WR_PL: begin
                state_d = S_WR_PH;
                if (cfg_stop) stop_pend_d = 1'b1; else stop_pend_d = stop_pend_q;
            end
            S_WR_PH: begin
                state_d = S_WR_CTL;
                if (cfg_stop) stop_pend_d = 1'b1; else stop_pend_d = stop_pend_q;
            end
            S_WR_CTL: begin
                state_d = S_RUN;
                if (cfg_stop) stop_pend_d = 1'b1; else stop_pend_d = stop_pend_q;
            end
            S_RUN: begin
                // A stop request outranks a simultaneous timeout; that timeout is dropped.
                if (stop_pend_q || cfg_stop) begin
                    state_d = S_WR_STOP;
                end else if (tmr_irq) begin
                    state_d = S_CLR_STS;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_CLR_STS: begin
                state_d = S_TICK;
                if (cfg_stop) stop_pend_d = 1'b1; else stop_pend_d = stop_pend_q;
            end
            S_TICK: begin
                tick_count_d = tick_count_q + 32'd1;
                state_d      = S_RUN;
                if (cfg_stop) stop_pend_d = 1'b1; else stop_pend_d = stop_pend_q;
            end
            S_WR_STOP: begin
                stop_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs are decoded from the next state so they are registered.
    always_comb begin
        cs_d      = 1'b0;
        wr_n_d    = 1'b1;
        addr_d    = 3'd0;
        wdata_d   = 16'h0000;
        running_d = 1'b0;
        case (state_d)
            S_WR_PL:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd2; wdata_d = period_d[15:0];  end
            S_WR_PH:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd3; wdata_d = period_d[31:16]; end
            S_WR_CTL:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0007;        end
            S_CLR_STS: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd0; wdata_d = 16'h0000; running_d = 1'b1; end
            S_WR_STOP: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008;        end
            S_RUN:     begin running_d = 1'b1; end
            S_TICK:    begin running_d = 1'b1; end
            default:   begin running_d = 1'b0; end
        endcase
    end

    // Per-channel countdown: load beats cancel beats tick decrement.
    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        expire_d = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (ch_load[i]) begin
                cnt_d[i]    = ch_ticks[i*TICK_W +: TICK_W];
                busy_d[i]   = (ch_ticks[i*TICK_W +: TICK_W] != {TICK_W{1'b0}});
                expire_d[i] = (ch_ticks[i*TICK_W +: TICK_W] == {TICK_W{1'b0}});
            end else if (ch_cancel[i]) begin
                busy_d[i] = 1'b0;
            end else if ((state_q == S_TICK) && busy_q[i]) begin
                cnt_d[i] = cnt_q[i] - TICK_W'(1);
                if (cnt_q[i] == TICK_W'(1)) begin
                    busy_d[i]   = 1'b0;
                    expire_d[i] = 1'b1;
                end else begin
                    busy_d[i]   = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            period_q     <= 32'd0;
            stop_pend_q  <= 1'b0;
            running_q    <= 1'b0;
            tick_count_q <= 32'd0;
            addr_q       <= 3'd0;
            cs_q         <= 1'b0;
            wr_n_q       <= 1'b1;
            wdata_q      <= 16'h0000;
            cnt_q        <= '0;
            busy_q       <= {N_CH{1'b0}};
            expire_q     <= {N_CH{1'b0}};
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            stop_pend_q  <= stop_pend_d;
            running_q    <= running_d;
            tick_count_q <= tick_count_d;
            addr_q       <= addr_d;
            cs_q         <= cs_d;
            wr_n_q       <= wr_n_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            expire_q     <= expire_d;
        end
    end

    assign running        = running_q;
    assign tick_count     = tick_count_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wr_n_q;
    assign tmr_writedata  = wdata_q;
    assign ch_busy        = busy_q;
    assign ch_expire      = expire_q;

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed bench for timer_tick_scheduler: a cycle-queue model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_timer_tick_scheduler;

    localparam int N  = 4;
    localparam int TW = 16;
    localparam logic [1:0] K_IDLE = 2'd0, K_RUN = 2'd1, K_SEQ = 2'd2, K_STOP = 2'd3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [31:0]       cfg_period;
    logic              cfg_start, cfg_stop;
    logic              running;
    logic [31:0]       tick_count;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect, tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic              tmr_irq;
    logic [N-1:0]      ch_load, ch_cancel, ch_busy, ch_expire;
    logic [N*TW-1:0]   ch_ticks;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt [N];

    timer_tick_scheduler #(.N_CH(N), .TICK_W(TW), .MIN_PERIOD(7)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .running(running), .tick_count(tick_count),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq), .ch_load(ch_load),
        .ch_ticks(ch_ticks), .ch_cancel(ch_cancel), .ch_busy(ch_busy), .ch_expire(ch_expire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: each cycle is one item of a queue ----------------
    typedef struct packed {
        logic [1:0]  kind;
        logic        wr;
        logic [2:0]  a;
        logic [15:0] d;
        logic        run;
        logic        tk;
    } item_t;

    function automatic item_t mk(input logic [1:0] k, input logic wr, input logic [2:0] a,
                                 input logic [15:0] d, input logic run, input logic tk);
        item_t it;
        it.kind = k; it.wr = wr; it.a = a; it.d = d; it.run = run; it.tk = tk;
        return it;
    endfunction

    item_t          m_cur;
    item_t          m_q [$];
    logic           m_pend;
    logic [31:0]    m_tc, m_p;
    logic [TW-1:0]  m_cnt [N];
    logic [TW-1:0]  m_v;
    logic [N-1:0]   m_busy, m_exp;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cur  = mk(K_IDLE, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
            m_q.delete();
            m_pend = 1'b0;
            m_tc   = 32'd0;
            m_busy = '0;
            m_exp  = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_exp[i] = 1'b0;
                m_v = ch_ticks[i*TW +: TW];
                if (ch_load[i]) begin
                    m_cnt[i] = m_v; m_busy[i] = (m_v != 0); m_exp[i] = (m_v == 0);
                end else if (ch_cancel[i]) begin
                    m_busy[i] = 1'b0;
                end else if (m_cur.tk && m_busy[i]) begin
                    m_cnt[i] = m_cnt[i] - 1;
                    if (m_cnt[i] == 0) begin m_busy[i] = 1'b0; m_exp[i] = 1'b1; end
                end
            end
            if (m_cur.tk) m_tc = m_tc + 1;
            if (m_cur.kind == K_SEQ && cfg_stop) m_pend = 1'b1;
            if (m_cur.kind == K_STOP) m_pend = 1'b0;
            if (m_q.size() == 0) begin
                if (m_cur.kind == K_IDLE && cfg_start) begin
                    m_p = (cfg_period < 7) ? 32'd7 : cfg_period;
                    m_q.push_back(mk(K_SEQ, 1'b1, 3'd2, m_p[15:0], 1'b0, 1'b0));
                    m_q.push_back(mk(K_SEQ, 1'b1, 3'd3, m_p[31:16], 1'b0, 1'b0));
                    m_q.push_back(mk(K_SEQ, 1'b1, 3'd1, 16'h0007, 1'b0, 1'b0));
                    m_q.push_back(mk(K_RUN, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0));
                end else if (m_cur.kind == K_RUN && (m_pend || cfg_stop)) begin
                    m_q.push_back(mk(K_STOP, 1'b1, 3'd1, 16'h0008, 1'b0, 1'b0));
                    m_q.push_back(mk(K_IDLE, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0));
                end else if (m_cur.kind == K_RUN && tmr_irq) begin
                    m_q.push_back(mk(K_SEQ, 1'b1, 3'd0, 16'h0000, 1'b1, 1'b0));
                    m_q.push_back(mk(K_SEQ, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1));
                    m_q.push_back(mk(K_RUN, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0));
                end
            end
            if (m_q.size() != 0) m_cur = m_q.pop_front();
        end
    end

    // Compare process: every cycle out of reset.
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            chk("bus", {43'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
                {43'd0, m_cur.wr, ~m_cur.wr, m_cur.a, m_cur.d});
            chk("running", {63'd0, running}, {63'd0, m_cur.run});
            chk("tick_count", {32'd0, tick_count}, {32'd0, m_tc});
            chk("ch_busy", {60'd0, ch_busy}, {60'd0, m_busy});
            chk("ch_expire", {60'd0, ch_expire}, {60'd0, m_exp});
        end
    end

    // Expiry pulse counter for the literal checks.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) if (ch_expire[i]) exp_cnt[i]++;
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_bus(input string name, input logic [2:0] a, input logic [15:0] d);
        chk(name, {43'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
            {43'd0, 1'b1, 1'b0, a, d});
    endtask

    task automatic do_tick();
        tmr_irq = 1'b1;
        cyc(2);
        tmr_irq = 1'b0;
        cyc(2);
    endtask

    initial begin
        reset_n = 1'b0; cfg_period = 32'd0; cfg_start = 1'b0; cfg_stop = 1'b0;
        tmr_irq = 1'b0; ch_load = '0; ch_cancel = '0; ch_ticks = '0;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        chk("reset_running", {63'd0, running}, 64'd0);
        chk("reset_tick_count", {32'd0, tick_count}, 64'd0);
        chk("reset_idle_bus", {62'd0, tmr_chipselect, tmr_write_n}, 64'd1);

        // Reset in the middle of programming.
        cfg_period = 32'h1234_5678; cfg_start = 1'b1;
        cyc(1); cfg_start = 1'b0;
        cyc(1);
        expect_bus("wr_ph_before_reset", 3'd3, 16'h1234);
        reset_n = 1'b0;
        #1;
        chk("midreset_outputs", {39'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, running, ch_busy},
            {39'd0, 1'b0, 1'b1, 3'd0, 16'h0000, 1'b0, 4'b0000});
        cyc(1); reset_n = 1'b1;
        cyc(2);
        chk("idle_after_reset", {62'd0, tmr_chipselect, running}, 64'd0);

        // Program 0x186A0 and run.
        cfg_period = 32'h0001_86A0; cfg_start = 1'b1;
        cyc(1); cfg_start = 1'b0;
        expect_bus("wr_pl", 3'd2, 16'h86A0);
        cyc(1); expect_bus("wr_ph", 3'd3, 16'h0001);
        cyc(1); expect_bus("wr_ctl", 3'd1, 16'h0007);
        cyc(1);
        chk("running_after_ctl", {63'd0, running}, 64'd1);

        // One timeout, irq held an extra cycle.
        tmr_irq = 1'b1;
        cyc(1); expect_bus("clr_sts", 3'd0, 16'h0000);
        cyc(1); tmr_irq = 1'b0;
        cyc(1);
        chk("tick_count_1", {32'd0, tick_count}, 64'd1);
        cyc(3);
        chk("tick_count_still_1", {32'd0, tick_count}, 64'd1);

        // Channels: ch2 = 3 ticks, ch0 = 0 ticks, ch1 = 5 ticks then cancelled.
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        ch_ticks[0*TW +: TW] = 16'd0;
        ch_ticks[1*TW +: TW] = 16'd5;
        ch_ticks[2*TW +: TW] = 16'd3;
        ch_load = 4'b0111;
        cyc(1); ch_load = '0;
        chk("busy_after_load", {60'd0, ch_busy}, {60'd0, 4'b0110});
        chk("expire_zero_load", {60'd0, ch_expire}, {60'd0, 4'b0001});
        do_tick();
        do_tick();
        ch_cancel = 4'b0010;
        cyc(1); ch_cancel = '0;
        chk("busy_after_cancel", {60'd0, ch_busy}, {60'd0, 4'b0100});
        do_tick();
        chk("busy_after_3_ticks", {60'd0, ch_busy}, 64'd0);
        chk("exp_cnt_ch0", 64'(exp_cnt[0]), 64'd1);
        chk("exp_cnt_ch1", 64'(exp_cnt[1]), 64'd0);
        chk("exp_cnt_ch2", 64'(exp_cnt[2]), 64'd1);
        chk("tick_count_4", {32'd0, tick_count}, 64'd4);

        // Load during the TICK cycle wins over the decrement.
        ch_ticks[3*TW +: TW] = 16'd1; ch_load = 4'b1000;
        cyc(1); ch_load = '0;
        tmr_irq = 1'b1;
        cyc(2);
        tmr_irq = 1'b0;
        ch_ticks[3*TW +: TW] = 16'd2; ch_load = 4'b1000;
        cyc(1); ch_load = '0;
        cyc(1);
        chk("load_in_tick_no_expire", 64'(exp_cnt[3]), 64'd0);
        chk("load_in_tick_busy", {63'd0, ch_busy[3]}, 64'd1);
        do_tick();
        chk("ch3_after_1_tick", 64'(exp_cnt[3]), 64'd0);
        do_tick();
        chk("ch3_after_2_ticks", 64'(exp_cnt[3]), 64'd1);
        chk("tick_count_7", {32'd0, tick_count}, 64'd7);

        // Stop from RUN.
        cfg_stop = 1'b1;
        cyc(1); cfg_stop = 1'b0;
        expect_bus("wr_stop", 3'd1, 16'h0008);
        cyc(1);
        chk("stopped", {62'd0, running, tmr_chipselect}, 64'd0);

        // Counters freeze while stopped: irq is ignored in IDLE.
        ch_ticks[2*TW +: TW] = 16'd2; ch_load = 4'b0100;
        cyc(1); ch_load = '0;
        tmr_irq = 1'b1;
        cyc(2); tmr_irq = 1'b0;
        cyc(1);
        chk("frozen_busy", {63'd0, ch_busy[2]}, 64'd1);
        chk("frozen_tick_count", {32'd0, tick_count}, 64'd7);

        // Clamped period with a stop arriving during WR_PL.
        cfg_period = 32'd3; cfg_start = 1'b1;
        cyc(1); cfg_start = 1'b0; cfg_stop = 1'b1;
        expect_bus("clamp_pl", 3'd2, 16'h0007);
        cyc(1); cfg_stop = 1'b0;
        expect_bus("clamp_ph", 3'd3, 16'h0000);
        cyc(1); expect_bus("pend_ctl", 3'd1, 16'h0007);
        cyc(1);
        chk("pend_one_run_cycle", {62'd0, running, tmr_chipselect}, 64'd2);
        cyc(1); expect_bus("pend_stop", 3'd1, 16'h0008);
        chk("pend_stop_running", {63'd0, running}, 64'd0);
        cyc(1);
        chk("pend_idle", {62'd0, running, tmr_chipselect}, 64'd0);

        // Restart resumes the frozen channel.
        cfg_period = 32'd10; cfg_start = 1'b1;
        cyc(1); cfg_start = 1'b0;
        cyc(4);
        do_tick();
        do_tick();
        chk("resumed_expire_ch2", 64'(exp_cnt[2]), 64'd2);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/timer_tick_scheduler.md
Name: timer_tick_scheduler

Overview:
- Avalon-MM master that owns the system interval timer (16-bit data, 3-bit word address, registered readdata, irq output).
- Programs the timer's period, starts it in continuous mode with interrupt enabled, and acknowledges every timeout.
- Distributes each timer tick to N_CH independent software-visible countdown channels (robot motion and game-event timeouts), so one hardware timer serves all requesters.
- Sits between the control logic / CPU-side registers and the timer peripheral.

Parameters:
- N_CH, 4, number of countdown channels.
- TICK_W, 16, width of each channel's tick count.
- MIN_PERIOD, 7, minimum period value written to the timer; smaller requests are clamped up.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_period  in  32  timer period value, latched on cfg_start
- cfg_start  in  1  one-cycle pulse: program the timer and run
- cfg_stop  in  1  one-cycle pulse: stop the timer
- running  out  1  high while in RUN, CLR_STS or TICK
- tick_count  out  32  free-running count of acknowledged timeouts
- tmr_address  out  3  timer word address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  timer write strobe, active low
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt, level
- ch_load  in  N_CH  per-channel load pulse
- ch_ticks  in  N_CH*TICK_W  per-channel load value; channel i uses bits [i*TICK_W +: TICK_W]
- ch_cancel  in  N_CH  per-channel cancel pulse
- ch_busy  out  N_CH  channel counting
- ch_expire  out  N_CH  one-cycle expiry pulse

Behaviour:
- Reset values:
  - FSM in IDLE.
  - running=0, tick_count=0.
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
  - ch_busy=0, ch_expire=0; all channel counters 0; pending stop flag 0.
- All tmr_* outputs are registered. Each bus access is a single-cycle write with no waitrequest. tmr_chipselect=0 and tmr_write_n=1 in every non-write state.
- FSM states:
  - IDLE: on cfg_start, latch P = max(cfg_period, MIN_PERIOD), go to WR_PL. cfg_stop is ignored in IDLE.
  - WR_PL: write address 2, data P[15:0]; go to WR_PH.
  - WR_PH: write address 3, data P[31:16]; go to WR_CTL.
  - WR_CTL: write address 1, data 0x0007 (START | CONT | ITO); go to RUN.
  - RUN:
    - If the pending stop flag is set or cfg_stop is high: go to WR_STOP. Stop wins over a simultaneous irq, which is dropped.
    - Else if tmr_irq is high: go to CLR_STS.
    - cfg_start in RUN is ignored.
  - CLR_STS: write address 0, data 0x0000 (clears the timeout flag; irq falls next cycle); go to TICK.
  - TICK: tick_count += 1 (wraps at 2^32); every busy channel decrements; go to RUN.
  - WR_STOP: write address 1, data 0x0008 (STOP, ITO off); clear the pending stop flag; go to IDLE.
- A cfg_stop arriving in WR_PL, WR_PH, WR_CTL, CLR_STS or TICK sets the pending stop flag. The current sequence completes, then RUN exits to WR_STOP on its first cycle.
- Channel i, evaluated every cycle in any FSM state (priority order):
  - ch_load[i]: counter gets its ch_ticks slice.
    - Nonzero value: ch_busy[i]=1 next cycle.
    - Zero value: ch_busy stays 0 and ch_expire[i] pulses next cycle.
    - A load in the TICK cycle wins; no decrement that tick.
  - Else ch_cancel[i]: ch_busy[i] goes to 0 with no expire.
  - Else TICK state and ch_busy[i]: counter -= 1.
    - If the counter was 1, ch_busy[i] goes to 0 and ch_expire[i] pulses one cycle, registered (visible the cycle after TICK).
- Channel counters freeze (hold value and busy) while the timer is stopped and resume after the next cfg_start.
- Tick period equals the timer period as programmed (P+1 clk cycles). Channel expiry occurs on the Nth acknowledged tick after load.

Test Plan:
- Reset mid-sequence (assert reset_n=0 during WR_PH) -> all outputs at reset values immediately; FSM in IDLE after release.
- cfg_period=0x0001_86A0, cfg_start -> three consecutive writes: (2, 0x86A0), (3, 0x0001), (1, 0x0007); running=1 on the following cycle.
- cfg_period=3 -> period writes carry 0x0007 and 0x0000 (clamped).
- In RUN, raise tmr_irq -> write (0, 0x0000) next cycle, then tick_count increments by 1; irq held for one more cycle does not cause a second tick.
- ch_load[2] with ticks=3, deliver 3 irqs -> ch_busy[2] high until the 3rd TICK; a single ch_expire[2] pulse follows. ch_load[0] with ticks=0 -> immediate expire pulse, busy never set. ch_cancel[1] mid-count -> busy drops with no expire.
- cfg_stop during WR_PL -> WR_PH and WR_CTL complete, one RUN cycle, then write (1, 0x0008); running=0. A load and a tick in the same cycle on one channel -> counter equals the loaded value.
